// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) round-robin arbiter in front of a single-port
// word memory with a 1-cycle registered read. Requests are pre-checked for
// alignment and bounds; faulting requests answer without touching memory.
module mem_arbiter #(
  parameter int unsigned MEMORY_SIZE_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH        = $clog2(MEMORY_SIZE_WORDS * 4)
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,

  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_strb,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,

  output logic        mem_clk_enable,
  output logic        mem_r_en,
  output logic [31:0] mem_r_addr,
  input  logic [31:0] mem_r_data,
  output logic        mem_w_en,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [3:0]  mem_w_strb,
  input  logic [1:0]  mem_state,
  output logic        fault
);

  localparam logic [1:0]  MEMORY_STATE_SUCCESS = 2'd0;
  localparam logic [31:0] MEM_BYTES            = 32'(MEMORY_SIZE_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  // Request captured at accept; held until its response has gone out.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
    src_t        src;
    logic        err;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        rr_q, rr_d;          // 1: data port preferred on a tie
  logic        grant_i, grant_d;
  logic [31:0] acc_addr;
  logic        acc_err;
  logic        issue_d, resp_d;
  logic        i_rd_sel_q, d_rd_sel_q;

  // Arbitration, pre-check, capture and next-state selection.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rr_d        = rr_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    acc_addr    = '0;
    acc_err     = 1'b0;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;

    case (state_q)
      IDLE:    state_d = IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_q == RESP) begin
      grant_i = i_req_valid && (!d_req_valid || !rr_q);
      grant_d = d_req_valid && !grant_i;
    end
    i_req_ready = grant_i;
    d_req_ready = grant_d;

    acc_addr = grant_d ? d_req_addr : i_req_addr;
    acc_err  = (acc_addr[1:0] != 2'b00) || (acc_addr >= MEM_BYTES);

    if (grant_i || grant_d) begin
      req_d.addr  = acc_addr;
      req_d.we    = grant_d && d_req_we;
      req_d.wdata = grant_d ? d_req_wdata : '0;
      req_d.strb  = grant_d ? d_req_strb : '0;
      req_d.src   = grant_d ? SRC_D : SRC_I;
      req_d.err   = acc_err;
      rr_d        = grant_i;
      state_d     = acc_err ? RESP : ISSUE;
    end
  end

  assign issue_d = (state_d == ISSUE);
  assign resp_d  = (state_d == RESP);

  // State, captured request, pointer and registered strobes/response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_q          <= '0;
      rr_q           <= 1'b0;
      mem_clk_enable <= 1'b0;
      mem_r_en       <= 1'b0;
      mem_w_en       <= 1'b0;
      i_rsp_valid    <= 1'b0;
      i_rsp_err      <= 1'b0;
      d_rsp_valid    <= 1'b0;
      d_rsp_err      <= 1'b0;
      i_rd_sel_q     <= 1'b0;
      d_rd_sel_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      rr_q           <= rr_d;
      mem_clk_enable <= issue_d;
      mem_r_en       <= issue_d && !req_d.we;
      mem_w_en       <= issue_d && req_d.we;
      i_rsp_valid    <= resp_d && (req_d.src == SRC_I);
      i_rsp_err      <= resp_d && (req_d.src == SRC_I) && req_d.err;
      d_rsp_valid    <= resp_d && (req_d.src == SRC_D);
      d_rsp_err      <= resp_d && (req_d.src == SRC_D) && req_d.err;
      i_rd_sel_q     <= resp_d && (req_d.src == SRC_I) && !req_d.err;
      d_rd_sel_q     <= resp_d && (req_d.src == SRC_D) && !req_d.err && !req_d.we;
    end
  end

  // Memory address/data come straight from the captured request registers.
  assign mem_r_addr = 32'(req_q.addr[ADDR_WIDTH-1:0]);
  assign mem_w_addr = 32'(req_q.addr[ADDR_WIDTH-1:0]);
  assign mem_w_data = req_q.wdata;
  assign mem_w_strb = req_q.strb;

  // Read data arrives from the memory's own output register during RESP.
  assign i_rsp_data  = i_rd_sel_q ? mem_r_data : '0;
  assign d_rsp_rdata = d_rd_sel_q ? mem_r_data : '0;

  assign fault = (mem_state != MEMORY_STATE_SUCCESS);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port word memory (1-cycle registered read, byte-strobe writes, one operation per cycle) between two requesters: the instruction-fetch port (read-only) and the data load/store port (read/write).
- Valid/ready request handshake, registered issue, fixed-latency response.
- Round-robin arbitration between the two ports.
- Pre-checks alignment and bounds, so faulting accesses never reach the memory.

Parameters:
- MEMORY_SIZE_WORDS, 1024, words in the attached memory; used for the bounds check.
- ADDR_WIDTH, $clog2(MEMORY_SIZE_WORDS*4), byte-address bits decoded by the memory.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  32  fetch byte address
- i_rsp_valid  out  1  fetch response valid, one-cycle pulse
- i_rsp_data  out  32  fetch read data
- i_rsp_err  out  1  fetch access faulted
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  32  data byte address
- d_req_wdata  in  32  write data
- d_req_strb  in  4  write byte strobes
- d_rsp_valid  out  1  data response valid, one-cycle pulse
- d_rsp_rdata  out  32  read data; 0 for writes
- d_rsp_err  out  1  data access faulted
- mem_clk_enable  out  1  memory operation enable
- mem_r_en  out  1  memory read enable
- mem_r_addr  out  32  memory read address
- mem_r_data  in  32  memory read data (registered)
- mem_w_en  out  1  memory write enable
- mem_w_addr  out  32  memory write address
- mem_w_data  out  32  memory write data
- mem_w_strb  out  4  memory write strobes
- mem_state  in  2  memory status code (memory_states.vh)
- fault  out  1  high while mem_state != MEMORY_STATE_SUCCESS

Behaviour:
- Reset (async, rst_n low):
  - FSM to IDLE.
  - All *_rsp_valid, *_rsp_err, mem_* enables and captured-request registers cleared to 0.
  - Round-robin pointer set to "fetch preferred".
  - Any in-flight request is dropped with no response.
- FSM states: IDLE, ISSUE, RESP.
- Acceptance:
  - *_req_ready may be high only in IDLE or RESP, and only for the winning port; the loser's ready is 0.
  - A request transfers when valid && ready. Address, we, wdata, strb, source id and error flag are captured.
- Arbitration:
  - One port valid: that port wins.
  - Both valid: the port not granted last wins. The pointer updates on every accept.
- Pre-check at accept:
  - err = (addr[1:0] != 0) || (addr >= MEMORY_SIZE_WORDS*4), using the full 32-bit compare.
  - err: go to RESP directly; no memory enables asserted; rdata = 0.
  - No err: go to ISSUE.
- ISSUE (one cycle):
  - mem_clk_enable = 1.
  - Read: mem_r_en = 1, mem_w_en = 0, mem_r_addr = captured addr.
  - Write: mem_w_en = 1, mem_r_en = 0, mem_w_addr/data/strb = captured values.
  - Next state RESP.
- RESP (one cycle):
  - The source port's *_rsp_valid = 1; err as captured.
  - Read data is taken from mem_r_data, which is held because mem_clk_enable = 0.
  - Write response carries rdata = 0.
  - Next state: ISSUE, or RESP for an errored request, if a new request is accepted this cycle; otherwise IDLE.
- Enables outside ISSUE: mem_clk_enable, mem_r_en and mem_w_en are 0 in every other state. mem_r_en and mem_w_en are never both 1.
- Latency:
  - Good access: accept at edge N, ISSUE in cycle N+1, response in cycle N+2.
  - Errored access: response in cycle N+1.
  - Peak throughput: 1 access per 2 cycles.
- Response outputs are registered: they are driven in RESP, and valid/err/data are 0 otherwise. There is no response backpressure.
- Write corner cases:
  - d_req_we with strb = 4'b0000 is a legal write: full ISSUE cycle, memory contents unchanged, normal response.
  - The fetch port never writes.
- Simultaneous events: a response in RESP and acceptance of the next request in the same cycle are legal. The pointer update uses the new grant.
- fault: combinational from mem_state; sticky exactly as long as mem_state is.

Test Plan:
1. Fetch read at 0x10 (mem word 4 = 0xDEADBEEF) → ready in the accept cycle, mem_r_en for one cycle at 0x10, i_rsp_valid with data 0xDEADBEEF two cycles after accept, err = 0.
2. Data write 0x00000020, wdata 0x11223344, strb 4'b0101, then a data read of 0x20 with prior word 0xAABBCCDD → rdata 0xAA22CC44; each response two cycles after its accept.
3. Both ports valid continuously for 8 accepts from reset → grants alternate I, D, I, D…; one accept every 2 cycles; the responses route to the matching ports.
4. d_req_addr 0x00000006 and 0x00001000 with MEMORY_SIZE_WORDS = 1024 → d_rsp_err = 1 one cycle after accept, rdata 0; no mem_r_en or mem_w_en pulse; fault stays 0.
5. rst_n low in the ISSUE cycle of a read → all outputs 0 immediately (asynchronously), no response ever issued; the first request after release is the fetch port's when both are valid.
6. mem_state driven to OUT_OF_BOUNDS → fault = 1 the same cycle; arbitration continues unaffected.
